// File: rtl/hand_collector_if.sv
// rtl/hand_collector_if.sv - card input and sorted-hand output bus of the hand collector
interface hand_collector_if #(
    parameter int NUM_CARDS = 7,
    parameter int CARD_W    = 6
);
    logic                        card_valid;
    logic [CARD_W-1:0]           card_in;
    logic                        card_ready;
    logic [NUM_CARDS*CARD_W-1:0] cards;
    logic [2:0]                  count;
    logic                        hand_valid;
    logic                        reject;
    logic                        clear;

    modport master (
        output card_valid, card_in, clear,
        input  card_ready, cards, count, hand_valid, reject
    );

    modport slave (
        input  card_valid, card_in, clear,
        output card_ready, cards, count, hand_valid, reject
    );
endinterface

// File: rtl/hand_collector.sv
// rtl/hand_collector.sv - collects cards into a descending insertion-sorted 7-card hand
module hand_collector #(
    parameter int NUM_CARDS = 7,
    parameter int CARD_W    = 6
) (
    input  logic            clk,
    input  logic            reset,
    hand_collector_if.slave hc
);
    typedef enum logic {FILL, FULL} state_t;

    localparam logic [2:0] FULL_CNT = 3'(NUM_CARDS);

    logic [CARD_W-1:0] slot_q [NUM_CARDS];
    logic [CARD_W-1:0] slot_d [NUM_CARDS];
    logic [2:0]        count_q, count_d;
    logic              reject_q, reject_d;
    logic              hand_valid_q, hand_valid_d;
    state_t            state_q, state_d;

    logic [NUM_CARDS-1:0] less;
    logic [CARD_W-1:0]    new_key;
    logic [3:0]           rank;
    logic                 rank_ok;
    logic                 dup;
    logic                 accept;
    logic                 card_ready;

    assign card_ready = (count_q < FULL_CNT);

    always_comb begin
        rank    = hc.card_in[3:0];
        new_key = {hc.card_in[3:0], hc.card_in[5:4]};
        rank_ok = (rank >= 4'd2) && (rank <= 4'd14);
        dup     = 1'b0;
        less    = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            // Empty slots are 0, which also sorts below every legal key.
            if (slot_q[i] != '0 && slot_q[i] == hc.card_in) dup = 1'b1;
            less[i] = ({slot_q[i][3:0], slot_q[i][5:4]} < new_key);
        end
        accept = hc.card_valid && card_ready && rank_ok && !dup;

        slot_d       = slot_q;
        count_d      = count_q;
        state_d      = state_q;
        hand_valid_d = hand_valid_q;
        reject_d     = hc.card_valid && !accept;

        if (accept) begin
            // less[] is monotone (0..0 1..1); the first set bit is the insert slot.
            if (less[0]) slot_d[0] = hc.card_in;
            for (int i = 1; i < NUM_CARDS; i++) begin
                if (less[i]) slot_d[i] = less[i-1] ? slot_q[i-1] : hc.card_in;
            end
            count_d = count_q + 3'd1;
            if (count_q == FULL_CNT - 3'd1) begin
                state_d      = FULL;
                hand_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || hc.clear) begin
            for (int i = 0; i < NUM_CARDS; i++) slot_q[i] <= '0;
            count_q      <= '0;
            reject_q     <= 1'b0;
            hand_valid_q <= 1'b0;
            state_q      <= FILL;
        end else begin
            slot_q       <= slot_d;
            count_q      <= count_d;
            reject_q     <= reject_d;
            hand_valid_q <= hand_valid_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        hc.cards = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            hc.cards[(NUM_CARDS-1-i)*CARD_W +: CARD_W] = slot_q[i];
        end
    end

    assign hc.card_ready = card_ready;
    assign hc.count      = count_q;
    assign hc.hand_valid = hand_valid_q;
    assign hc.reject     = reject_q;
endmodule

// File: tb/tb_hand_collector.sv
// tb/tb_hand_collector.sv - scoreboard bench for hand_collector
module tb_hand_collector;
    localparam logic [5:0] C2C = 6'h02, CAH = 6'h1E, CKS = 6'h2D, C7D = 6'h37, C7C = 6'h07,
                           CTH = 6'h1A, C5S = 6'h25, CKD = 6'h3D, CQH = 6'h1C, C3C = 6'h03,
                           CAD = 6'h3E, CAS = 6'h2E, C9H = 6'h19, C2D = 6'h32, CJC = 6'h0B,
                           CR1 = 6'h01, CR15 = 6'h1F, E = 6'h00;

    typedef struct {
        int          id;
        logic [41:0] cards;
        logic [2:0]  count;
        logic        hand_valid;
        logic        reject;
        logic        card_ready;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   step = 0;
    exp_t exp_q [$];

    hand_collector_if hc ();

    hand_collector dut (
        .clk   (clk),
        .reset (reset),
        .hc    (hc)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] hand(input logic [5:0] a, b, c, d, e, f, g);
        return {a, b, c, d, e, f, g};
    endfunction

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h required %h", name, id, act, req);
        end
    endtask

    task automatic stim(input logic v, input logic [5:0] card, input logic clr, input logic rst,
                        input logic [41:0] exp_cards, input logic [2:0] exp_count, input logic exp_rej);
        exp_t e;
        @(negedge clk);
        hc.card_valid = v;
        hc.card_in    = card;
        hc.clear      = clr;
        reset         = rst;
        e.id          = step;
        e.cards       = exp_cards;
        e.count       = exp_count;
        e.hand_valid  = (exp_count == 3'd7);
        e.card_ready  = (exp_count != 3'd7);
        e.reject      = exp_rej;
        exp_q.push_back(e);
        step++;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cards", e.id, 64'(hc.cards), 64'(e.cards));
            chk("count", e.id, 64'(hc.count), 64'(e.count));
            chk("hand_valid", e.id, 64'(hc.hand_valid), 64'(e.hand_valid));
            chk("reject", e.id, 64'(hc.reject), 64'(e.reject));
            chk("card_ready", e.id, 64'(hc.card_ready), 64'(e.card_ready));
        end
    end

    initial begin
        hc.card_valid = 1'b0;
        hc.card_in    = '0;
        hc.clear      = 1'b0;

        stim(1, CAH, 0, 1, '0, 0, 0);
        // Full 7-card fill and sort
        stim(1, C2C, 0, 0, hand(C2C, E, E, E, E, E, E), 1, 0);
        stim(1, CAH, 0, 0, hand(CAH, C2C, E, E, E, E, E), 2, 0);
        stim(1, CKS, 0, 0, hand(CAH, CKS, C2C, E, E, E, E), 3, 0);
        stim(1, C7D, 0, 0, hand(CAH, CKS, C7D, C2C, E, E, E), 4, 0);
        stim(1, C7C, 0, 0, hand(CAH, CKS, C7D, C7C, C2C, E, E), 5, 0);
        stim(1, CTH, 0, 0, hand(CAH, CKS, CTH, C7D, C7C, C2C, E), 6, 0);
        stim(1, C5S, 0, 0, hand(CAH, CKS, CTH, C7D, C7C, C5S, C2C), 7, 0);
        // Overflow while full, then hold, then clear
        stim(1, CQH, 0, 0, hand(CAH, CKS, CTH, C7D, C7C, C5S, C2C), 7, 1);
        stim(0, E,   0, 0, hand(CAH, CKS, CTH, C7D, C7C, C5S, C2C), 7, 0);
        stim(0, E,   1, 0, '0, 0, 0);
        // Duplicate rejection and same-rank suit ordering
        stim(1, C2C, 0, 0, hand(C2C, E, E, E, E, E, E), 1, 0);
        stim(1, CAH, 0, 0, hand(CAH, C2C, E, E, E, E, E), 2, 0);
        stim(1, CKS, 0, 0, hand(CAH, CKS, C2C, E, E, E, E), 3, 0);
        stim(1, CKS, 0, 0, hand(CAH, CKS, C2C, E, E, E, E), 3, 1);
        stim(1, CKD, 0, 0, hand(CAH, CKD, CKS, C2C, E, E, E), 4, 0);
        // Clear beats a same-cycle card, no reject pulse
        stim(1, CAH, 1, 0, '0, 0, 0);
        // Bad ranks on consecutive cycles
        stim(1, CR1,  0, 0, '0, 0, 1);
        stim(1, CR15, 0, 0, '0, 0, 1);
        stim(0, E,    0, 0, '0, 0, 0);
        // Reset mid-fill with card_valid high
        stim(1, C2C, 0, 0, hand(C2C, E, E, E, E, E, E), 1, 0);
        stim(1, CAH, 0, 0, hand(CAH, C2C, E, E, E, E, E), 2, 0);
        stim(1, CKS, 0, 0, hand(CAH, CKS, C2C, E, E, E, E), 3, 0);
        stim(1, C7D, 0, 0, hand(CAH, CKS, C7D, C2C, E, E, E), 4, 0);
        stim(1, C7C, 0, 0, hand(CAH, CKS, C7D, C7C, C2C, E, E), 5, 0);
        stim(1, CTH, 0, 1, '0, 0, 0);
        // Fresh hand after reset
        stim(1, CQH, 0, 0, hand(CQH, E, E, E, E, E, E), 1, 0);
        stim(1, C3C, 0, 0, hand(CQH, C3C, E, E, E, E, E), 2, 0);
        stim(1, CAD, 0, 0, hand(CAD, CQH, C3C, E, E, E, E), 3, 0);
        stim(1, CAS, 0, 0, hand(CAD, CAS, CQH, C3C, E, E, E), 4, 0);
        stim(1, C9H, 0, 0, hand(CAD, CAS, CQH, C9H, C3C, E, E), 5, 0);
        stim(1, C2D, 0, 0, hand(CAD, CAS, CQH, C9H, C3C, C2D, E), 6, 0);
        stim(1, CJC, 0, 0, hand(CAD, CAS, CQH, CJC, C9H, C3C, C2D), 7, 0);
        stim(0, E,   0, 0, hand(CAD, CAS, CQH, CJC, C9H, C3C, C2D), 7, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hand_collector.md
Name: hand_collector

Overview:
- Producer side of the 7-card hand bus consumed by the hand evaluator.
- Accepts cards one at a time from the dealer or deck logic and keeps them in a register array, insertion-sorted in descending order.
- After the last card is accepted, presents the full 42-bit sorted hand: highest card in [41:36], each card {suit[5:4], rank[3:0]}.
- Rejects malformed and duplicate cards so the evaluator only ever sees a legal, sorted hand.

Parameters:
NUM_CARDS, 7, number of card slots in a hand.
CARD_W, 6, bits per card: suit 2 MSBs (C=00, H=01, S=10, D=11), rank 4 LSBs (2..14, A=14).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous flush of the hand; same effect as reset on this block
card_valid  input  1  card_in is presented this cycle
card_in  input  CARD_W  card to insert, {suit, rank}
card_ready  output  1  block can accept a card this cycle
cards  output  NUM_CARDS*CARD_W  sorted hand; slot 0 = [41:36] highest, empty slots = 0
count  output  3  number of cards currently held (0..7)
hand_valid  output  1  level; high while count == NUM_CARDS
reject  output  1  one-cycle pulse: offered card dropped (bad rank, duplicate or full)

Behaviour:
- Reset or clear: all slots = 0, count = 0, hand_valid = 0, reject = 0, card_ready = 1. Clear has priority over a same-cycle card_valid; that card is dropped with no reject pulse.
- Accept: card_valid && card_ready. Accepted card is visible on cards/count on the next clock edge (1-cycle latency). No combinational path from card_in to cards.
- card_ready = (count < NUM_CARDS). It is combinational from registered count only.
- Sort key is the 6-bit value {rank, suit} compared unsigned, descending.
  - Equal ranks order by suit code descending: D > S > H > C.
  - Keys are unique, so no stable-order rule is needed.
- Insertion in one cycle:
  - Find the first slot i whose key is less than the new key. Empty slots (0) always compare less.
  - Slots i..NUM_CARDS-2 shift down one position; the new card is written to slot i.
  - Slot NUM_CARDS-1 is overwritten only when it is empty, which is guaranteed because insertion happens only when count < NUM_CARDS.
- Validity checks are done combinationally in the accept cycle. On failure, no state changes and reject pulses high on the next cycle.
  - Rank < 2 or rank > 14.
  - Exact {suit, rank} already held in any occupied slot.
  - card_valid while full (card_ready = 0). This is the overflow case; the hand is unchanged.
- State machine, encoded by count:
  - FILL (count 0..6): accepts cards.
  - FULL (count 7): hand_valid = 1 and cards is held stable until clear or reset.
  - FILL to FULL takes place on the edge that accepts the 7th card, so hand_valid rises in the same cycle that card appears.
- Reset or clear mid-fill discards all partial state; there is no pending operation to complete.
- reject is a registered pulse, high for exactly one cycle per dropped card. Back-to-back bad cards give back-to-back pulses.
- count increments by exactly 1 per accept and never exceeds NUM_CARDS.

Test Plan:
- Reset, then insert 2C(00_0010), AH(01_1110), KS(10_1101), 7D(11_0111), 7C(00_0111), TH(01_1010), 5S(10_0101) on consecutive cycles. Required response: cards = AH,KS,TH,7D,7C,5S,2C from [41:36] down; count = 7; hand_valid = 1 the cycle after the 7th card; card_ready = 0.
- After 3 cards, offer KS again (10_1101). Required response: reject pulses 1 cycle, count stays 3, cards unchanged. Then offer KD (11_1101): it is inserted above KS.
- Offer rank 1 (00_0001) and rank 15 (01_1111). Required response: both rejected with one pulse each on consecutive cycles; count = 0; all slots = 0.
- With a full hand, offer QH. Required response: reject pulses, cards and count unchanged, hand_valid stays 1. Then assert clear: next cycle count = 0, hand_valid = 0, cards = 0, card_ready = 1.
- Assert clear and card_valid (AH) in the same cycle with count = 4. Required response: count = 0, AH not stored, no reject pulse.
- Assert reset after 5 cards while card_valid is also high. Required response: all outputs at reset values next cycle. Then a fresh 7-card sequence fills and sorts correctly.
